// File: rtl/rv32_pkg.sv
// Shared RV32 load/store encodings and the dmem_ctrl state encoding.
// Used by dmem_ctrl and dmem_lane_align.
package rv32_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } dmem_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } mem_size_e;

  // Reserved encodings (011/110/111) behave as full-word accesses.
  function automatic mem_size_e f3_size(input logic [2:0] f3);
    mem_size_e sz;
    case (f3)
      F3_B, F3_BU: sz = SZ_B;
      F3_H, F3_HU: sz = SZ_H;
      default:     sz = SZ_W;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: store byte enables / lane replication and
// load lane extraction with sign or zero extension.
module dmem_lane_align
  import rv32_pkg::*;
(
  input  mem_size_e   st_size_i,
  input  logic [1:0]  st_lo_i,
  input  logic [31:0] st_wdata_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_lo_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ld_signed;

  always_comb begin
    st_be_o    = 4'b1111;
    st_wdata_o = st_wdata_i;
    case (st_size_i)
      SZ_B: begin
        st_be_o    = 4'b0001 << st_lo_i;
        st_wdata_o = {4{st_wdata_i[7:0]}};
      end
      SZ_H: begin
        st_be_o    = st_lo_i[1] ? 4'b1100 : 4'b0011;
        st_wdata_o = {2{st_wdata_i[15:0]}};
      end
      default: begin
        st_be_o    = 4'b1111;
        st_wdata_o = st_wdata_i;
      end
    endcase
  end

  // funct3[2] clear means a signed load (LB/LH).
  assign ld_byte   = ld_rdata_i[{ld_lo_i, 3'b000} +: 8];
  assign ld_half   = ld_rdata_i[{ld_lo_i[1], 4'b0000} +: 16];
  assign ld_signed = ~ld_funct3_i[2];

  always_comb begin
    ld_data_o = ld_rdata_i;
    case (f3_size(ld_funct3_i))
      SZ_B:    ld_data_o = {{24{ld_signed & ld_byte[7]}}, ld_byte};
      SZ_H:    ld_data_o = {{16{ld_signed & ld_half[15]}}, ld_half};
      default: ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory sequencer: IDLE -> REQ -> DONE over a req/ack port.
// Optional DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses complete without a bus request.
module dmem_ctrl
  import rv32_pkg::*;
#(
  parameter int AddrWidth     = 10,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_read_i,
  input  logic                 mem_write_i,
  input  logic [2:0]           funct3_i,
  input  logic [31:0]          addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic                 stall_o,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 done_o,
  output logic                 bus_err_o,
  output logic                 dmem_req_o,
  output logic                 dmem_we_o,
  output logic [AddrWidth-1:0] dmem_addr_o,
  output logic [3:0]           dmem_be_o,
  output logic [DataWidth-1:0] dmem_wdata_o,
  input  logic                 dmem_ack_i,
  input  logic [DataWidth-1:0] dmem_rdata_i,
`ifdef DMEM_MISALIGN_TRAP_EN
  output logic                 misalign_o,
`endif
  output dmem_state_e          dbg_state_o
);

  localparam int CntW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  // Handshake: dmem_req_o rises on entry to REQ and holds, with stable
  // we/addr/be/wdata, until the cycle dmem_ack_i is sampled high; read data
  // is taken in that same cycle. There is no backpressure from this side.

  dmem_state_e state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 req_q, req_d;
  logic                 we_q, we_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [3:0]           be_q, be_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [2:0]           ld_f3_q, ld_f3_d;
  logic [1:0]           ld_lo_q, ld_lo_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 bus_err_q, bus_err_d;

  logic        mem_req;
  logic        accept;
  logic        complete;
  logic        timeout;
  mem_size_e   size_in;
  logic [1:0]  addr_lo;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;
  logic        unused_addr_hi;

  assign mem_req        = mem_read_i | mem_write_i;
  assign size_in        = f3_size(funct3_i);
  assign unused_addr_hi = ^addr_i[31:AddrWidth+2];

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misaligned;
  logic trap;
  logic misalign_q;

  assign misaligned = ((size_in == SZ_H) & addr_i[0]) |
                      ((size_in == SZ_W) & (|addr_i[1:0]));
  assign addr_lo    = addr_i[1:0];
`else
  // Without the trap, sub-word offset bits that cannot be legal are ignored.
  always_comb begin
    case (size_in)
      SZ_H:    addr_lo = {addr_i[1], 1'b0};
      SZ_W:    addr_lo = 2'b00;
      default: addr_lo = addr_i[1:0];
    endcase
  end
`endif

  dmem_lane_align u_lane_align (
    .st_size_i   (size_in),
    .st_lo_i     (addr_lo),
    .st_wdata_i  (wdata_i),
    .st_be_o     (st_be),
    .st_wdata_o  (st_wdata),
    .ld_funct3_i (ld_f3_q),
    .ld_lo_i     (ld_lo_q),
    .ld_rdata_i  (dmem_rdata_i),
    .ld_data_o   (ld_data)
  );

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    complete = 1'b0;
    timeout  = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    trap     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (mem_req) begin
`ifdef DMEM_MISALIGN_TRAP_EN
          if (misaligned) begin
            state_d = ST_DONE;
            trap    = 1'b1;
          end else begin
            state_d = ST_REQ;
            accept  = 1'b1;
          end
`else
          state_d = ST_REQ;
          accept  = 1'b1;
`endif
        end
      end
      ST_REQ: begin
        // An ack on the last allowed cycle still counts as a normal completion.
        if (dmem_ack_i) begin
          state_d  = ST_DONE;
          complete = 1'b1;
        end else if (cnt_q == CntLast) begin
          state_d = ST_DONE;
          timeout = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    ld_f3_d   = ld_f3_q;
    ld_lo_d   = ld_lo_q;
    rdata_d   = rdata_q;
    bus_err_d = timeout;
    if (accept) begin
      cnt_d   = '0;
      req_d   = 1'b1;
      we_d    = mem_write_i;
      addr_d  = addr_i[AddrWidth+1:2];
      be_d    = st_be;
      wdata_d = st_wdata;
      ld_f3_d = funct3_i;
      ld_lo_d = addr_lo;
    end else if (state_q == ST_REQ) begin
      cnt_d = cnt_q + CntW'(1);
    end
    if (complete || timeout) begin
      cnt_d   = '0;
      req_d   = 1'b0;
      we_d    = 1'b0;
      addr_d  = '0;
      be_d    = '0;
      wdata_d = '0;
    end
    if (complete && !we_q) rdata_d = ld_data;
    if (timeout) rdata_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      ld_f3_q   <= '0;
      ld_lo_q   <= '0;
      rdata_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      ld_f3_q   <= ld_f3_d;
      ld_lo_q   <= ld_lo_d;
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= trap;
  end
  assign misalign_o = misalign_q;
`endif

  // Gating with rst lets a held request not re-raise stall while reset is applied.
  assign stall_o      = ~rst & (((state_q == ST_IDLE) & mem_req) | (state_q == ST_REQ));
  assign done_o       = (state_q == ST_DONE);
  assign bus_err_o    = bus_err_q;
  assign rdata_o      = rdata_q;
  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: driver tasks issue accesses and push expected
// bus requests / completions; a negedge monitor pops and compares.
module tb_dmem_ctrl;
  import rv32_pkg::*;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_i, mem_write_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        done_o, bus_err_o;
  logic        dmem_req_o, dmem_we_o;
  logic [9:0]  dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic        misalign_o;
`endif
  dmem_state_e dbg_state;

  int checks = 0;
  int errors = 0;

  // {bus_err, rdata} per completion; {we, addr, be, wdata} per acked request.
  logic [32:0] exp_q[$];
  logic [46:0] req_exp_q[$];
  logic [32:0] exp_done;
  logic [46:0] exp_req;

  dmem_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read_i   (mem_read_i),
    .mem_write_i  (mem_write_i),
    .funct3_i     (funct3_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .stall_o      (stall_o),
    .rdata_o      (rdata_o),
    .done_o       (done_o),
    .bus_err_o    (bus_err_o),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_be_o    (dmem_be_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_ack_i   (dmem_ack_i),
    .dmem_rdata_i (dmem_rdata_i),
`ifdef DMEM_MISALIGN_TRAP_EN
    .misalign_o   (misalign_o),
`endif
    .dbg_state_o  (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (dmem_req_o && dmem_ack_i) begin
        if (req_exp_q.size() == 0) check("req_unexpected", 1, 0);
        else begin
          exp_req = req_exp_q.pop_front();
          check("dmem_req", {dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o}, exp_req);
        end
      end
      if (done_o) begin
        if (exp_q.size() == 0) check("done_unexpected", 1, 0);
        else begin
          exp_done = exp_q.pop_front();
          check("done_resp", {bus_err_o, rdata_o}, exp_done);
        end
      end
    end
  end

  // Driver: lat = REQ cycle index carrying the ack, or -1 for no ack.
  task automatic do_access(input string name, input logic rd, input logic wr,
                           input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input int lat, input logic [31:0] word,
                           input logic [46:0] e_req, input logic [32:0] e_done);
    int req_cycles;
    int exp_cycles;
    @(posedge clk); #2;
    mem_read_i = rd; mem_write_i = wr; funct3_i = f3; addr_i = addr; wdata_i = wd;
    if (lat >= 0 && lat < TIMEOUT) req_exp_q.push_back(e_req);
    exp_q.push_back(e_done);
    #1 check({name, "_stall_idle"}, stall_o, 1);
    @(posedge clk); #2;
    req_cycles = 0;
    for (int k = 0; k < 40; k++) begin
      dmem_ack_i   = (k == lat);
      dmem_rdata_i = (k == lat) ? word : 32'h0;
      #1;
      if (!dmem_req_o) break;
      if (k == 0) check({name, "_stall_req"}, stall_o, 1);
      req_cycles++;
      @(posedge clk); #2;
    end
    dmem_ack_i = 1'b0; dmem_rdata_i = 32'h0;
    exp_cycles = (lat < 0 || lat >= TIMEOUT) ? TIMEOUT : lat + 1;
    check({name, "_req_cycles"}, req_cycles, exp_cycles);
    check({name, "_done"}, done_o, 1);
    check({name, "_stall_done"}, stall_o, 0);
    @(posedge clk); #1;
    check({name, "_no_reaccept"}, {done_o, dmem_req_o}, 0);
    #1;
    mem_read_i = 1'b0; mem_write_i = 1'b0; funct3_i = 3'b0; addr_i = 32'h0; wdata_i = 32'h0;
  endtask

  task automatic do_reset_mid_access();
    @(posedge clk); #2;
    mem_read_i = 1'b1; funct3_i = F3_W; addr_i = 32'h50;
    repeat (3) begin @(posedge clk); #2; end
    check("rst_pre_req", dmem_req_o, 1);
    rst = 1'b1;
    #1;
    check("rst_req_drop", dmem_req_o, 0);
    check("rst_stall_drop", stall_o, 0);
    check("rst_state", dbg_state, ST_IDLE);
    mem_read_i = 1'b0; funct3_i = 3'b0; addr_i = 32'h0;
    @(posedge clk); #2;
    rst = 1'b0;
    #1 check("rst_rdata_clear", {done_o, rdata_o}, 0);
  endtask

  initial begin
    rst = 1'b1;
    mem_read_i = 1'b0; mem_write_i = 1'b0; funct3_i = 3'b0; addr_i = 32'h0;
    wdata_i = 32'h0; dmem_ack_i = 1'b0; dmem_rdata_i = 32'h0;
    #3;
    check("reset_outputs",
          {stall_o, done_o, bus_err_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o}, 0);
    check("reset_data", {rdata_o, dmem_wdata_o}, 0);
    check("reset_state", dbg_state, ST_IDLE);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    do_access("lw_0x10", 1, 0, F3_W, 32'h10, 0, 0, 32'hDEADBEEF,
              {1'b0, 10'd4, 4'b1111, 32'h0}, {1'b0, 32'hDEADBEEF});
    do_access("sb_0x3", 0, 1, F3_B, 32'h3, 32'h000000A5, 1, 32'h0,
              {1'b1, 10'd0, 4'b1000, 32'hA5A5A5A5}, {1'b0, 32'hDEADBEEF});
    do_access("lb_0x1", 1, 0, F3_B, 32'h1, 0, 0, 32'h00008000,
              {1'b0, 10'd0, 4'b0010, 32'h0}, {1'b0, 32'hFFFFFF80});
    do_access("lbu_0x1", 1, 0, F3_BU, 32'h1, 0, 2, 32'h00008000,
              {1'b0, 10'd0, 4'b0010, 32'h0}, {1'b0, 32'h00000080});
    do_access("lh_0x2", 1, 0, F3_H, 32'h2, 0, 0, 32'h80000000,
              {1'b0, 10'd0, 4'b1100, 32'h0}, {1'b0, 32'hFFFF8000});
    do_access("lhu_0x2", 1, 0, F3_HU, 32'h2, 0, 1, 32'h80000000,
              {1'b0, 10'd0, 4'b1100, 32'h0}, {1'b0, 32'h00008000});
    do_access("sh_0x2", 0, 1, F3_H, 32'h2, 32'h00001234, 0, 32'h0,
              {1'b1, 10'd0, 4'b1100, 32'h12341234}, {1'b0, 32'h00008000});

`ifdef DMEM_MISALIGN_TRAP_EN
    @(posedge clk); #2;
    mem_read_i = 1'b1; funct3_i = F3_W; addr_i = 32'h6;
    exp_q.push_back({1'b0, 32'h00008000});
    @(posedge clk); #1;
    check("mis_lw_done", {done_o, misalign_o, dmem_req_o}, 3'b110);
    @(posedge clk); #1;
    check("mis_lw_clear", {done_o, misalign_o, dmem_req_o}, 0);
    #1 mem_read_i = 1'b0; funct3_i = 3'b0; addr_i = 32'h0;
`else
    do_access("lw_0x6", 1, 0, F3_W, 32'h6, 0, 3, 32'h11223344,
              {1'b0, 10'd1, 4'b1111, 32'h0}, {1'b0, 32'h11223344});
`endif

    do_access("lw_timeout", 1, 0, F3_W, 32'h40, 0, -1, 32'h0,
              47'h0, {1'b1, 32'h0});
    do_access("lw_ack_last", 1, 0, F3_W, 32'h44, 0, 15, 32'hCAFEF00D,
              {1'b0, 10'h11, 4'b1111, 32'h0}, {1'b0, 32'hCAFEF00D});

    do_reset_mid_access();

    do_access("lw_after_rst", 1, 0, F3_W, 32'h20, 0, 2, 32'h0BADF00D,
              {1'b0, 10'd8, 4'b1111, 32'h0}, {1'b0, 32'h0BADF00D});
    do_access("sw_0x24", 0, 1, F3_W, 32'h24, 32'h55AA55AA, 0, 32'h0,
              {1'b1, 10'd9, 4'b1111, 32'h55AA55AA}, {1'b0, 32'h0BADF00D});
    do_access("lb_pos_0x3", 1, 0, F3_B, 32'h3, 0, 0, 32'h7F000000,
              {1'b0, 10'd0, 4'b1000, 32'h0}, {1'b0, 32'h0000007F});
    do_access("f3_011_0x8", 1, 0, 3'b011, 32'h8, 0, 1, 32'h89ABCDEF,
              {1'b0, 10'd2, 4'b1111, 32'h0}, {1'b0, 32'h89ABCDEF});
    do_access("rw_both_0x30", 1, 1, F3_W, 32'h30, 32'h01020304, 0, 32'hFFFFFFFF,
              {1'b1, 10'd12, 4'b1111, 32'h01020304}, {1'b0, 32'h89ABCDEF});
    do_access("sb_0x1", 0, 1, F3_B, 32'h1, 32'h123456C3, 2, 32'h0,
              {1'b1, 10'd0, 4'b0010, 32'hC3C3C3C3}, {1'b0, 32'h89ABCDEF});

    repeat (4) @(posedge clk);
    #1;
    check("done_queue_drained", exp_q.size(), 0);
    check("req_queue_drained", req_exp_q.size(), 0);
    check("idle_at_end", dbg_state, ST_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
